shift_reg: RTL and testbench



---
 rtl/shift_reg_pkg.sv | 11 +
 rtl/shift_reg_dff_vec.sv | 26 ++
 rtl/shift_reg.sv | 106 ++++++++++
 tb/tb_shift_reg.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_reg_pkg.sv
// Shared types for the shift_reg block: the operating mode encoding.
package shift_reg_pkg;

   typedef enum logic [1:0] {
      HOLD      = 2'd0,
      SHIFT_FWD = 2'd1,
      SHIFT_BWD = 2'd2,
      LOAD      = 2'd3
   } shift_mode_e;

endpackage

// File: rtl/shift_reg_dff_vec.sv
// One storage stage: width_p-bit register with async active-low reset,
// synchronous clear and load enable.
module dff_vec #(
   parameter int                 width_p     = 8,
   parameter logic [width_p-1:0] reset_val_p = '0
) (
   input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic               clear_i,
   input  logic               en_i,
   input  logic [width_p-1:0] d_i,
   output logic [width_p-1:0] q_o
);

   // Stage register: reset and clear both return to reset_val_p, clear wins over enable.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         q_o <= reset_val_p;
      end else if (clear_i) begin
         q_o <= reset_val_p;
      end else if (en_i) begin
         q_o <= d_i;
      end
   end

endmodule

// File: rtl/shift_reg.sv
// Parametrised width_p x depth_p shift register with forward/backward shift,
// parallel load, synchronous clear and saturating fill tracking.
// Every output comes straight from a register; there is no input-to-output path.
module shift_reg
   import shift_reg_pkg::*;
#(
   parameter int                 width_p     = 8,
   parameter int                 depth_p     = 4,
   parameter logic [width_p-1:0] reset_val_p = '0
) (
   input  logic                           clk_i,
   input  logic                           reset_n_i,
   input  logic                           clear_i,
   input  logic                           en_i,
   input  logic [1:0]                     mode_i,
   input  logic [width_p-1:0]             data_i,
   input  logic [depth_p*width_p-1:0]     load_i,
   output logic [depth_p*width_p-1:0]     q_o,
   output logic [width_p-1:0]             head_o,
   output logic [width_p-1:0]             tail_o,
   output logic [$clog2(depth_p+1)-1:0]   fill_o,
   output logic                           full_o
);

   localparam int                fill_w   = $clog2(depth_p + 1);
   localparam logic [fill_w-1:0] fill_max = fill_w'(depth_p);

   shift_mode_e        mode;
   logic               stage_en;
   logic [width_p-1:0] stage [depth_p];
   logic [fill_w-1:0]  fill;

   assign mode     = shift_mode_e'(mode_i);
   // HOLD leaves every stage untouched, so only real operations enable the stages.
   assign stage_en = en_i && (mode != HOLD);

   for (genvar k = 0; k < depth_p; k++) begin : g_stage
      logic [width_p-1:0] fwd_src;
      logic [width_p-1:0] bwd_src;
      logic [width_p-1:0] nxt;

      // Stage 0 takes the serial word on a forward shift; others take their lower neighbour.
      if (k == 0) begin : g_fwd_head
         assign fwd_src = data_i;
      end else begin : g_fwd_mid
         assign fwd_src = stage[k-1];
      end

      // The last stage takes the serial word on a backward shift; others take their upper neighbour.
      if (k == depth_p - 1) begin : g_bwd_tail
         assign bwd_src = data_i;
      end else begin : g_bwd_mid
         assign bwd_src = stage[k+1];
      end

      // Next-value select for this stage according to the current mode.
      always_comb begin
         nxt = stage[k];
         case (mode)
            SHIFT_FWD: nxt = fwd_src;
            SHIFT_BWD: nxt = bwd_src;
            LOAD:      nxt = load_i[k*width_p +: width_p];
            default:   nxt = stage[k];
         endcase
      end

      dff_vec #(
         .width_p     (width_p),
         .reset_val_p (reset_val_p)
      ) u_dff (
         .clk_i     (clk_i),
         .reset_n_i (reset_n_i),
         .clear_i   (clear_i),
         .en_i      (stage_en),
         .d_i       (nxt),
         .q_o       (stage[k])
      );

      assign q_o[k*width_p +: width_p] = stage[k];
   end

   // Fill counter: counts valid stages, saturating at depth_p; a load fills every stage.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         fill <= '0;
      end else if (clear_i) begin
         fill <= '0;
      end else if (en_i) begin
         case (mode)
            SHIFT_FWD, SHIFT_BWD: begin
               if (fill != fill_max) begin
                  fill <= fill + 1'b1;
               end
            end
            LOAD:    fill <= fill_max;
            default: fill <= fill;
         endcase
      end
   end

   assign head_o = stage[0];
   assign tail_o = stage[depth_p-1];
   assign fill_o = fill;
   assign full_o = (fill == fill_max);

endmodule

// File: tb/tb_shift_reg.sv
// Directed bench for shift_reg: a 8x4 instance (reset value A5) and a 3x1 instance.
module tb_shift_reg;
   import shift_reg_pkg::*;

   logic        clk;
   logic        reset_n;
   logic        clear;
   logic        en;
   logic [1:0]  mode;
   logic [7:0]  data;
   logic [31:0] load;
   logic [31:0] q;
   logic [7:0]  head;
   logic [7:0]  tail;
   logic [2:0]  fill;
   logic        full;

   logic        clear1;
   logic        en1;
   logic [1:0]  mode1;
   logic [2:0]  data1;
   logic [2:0]  load1;
   logic [2:0]  q1;
   logic [2:0]  head1;
   logic [2:0]  tail1;
   logic [0:0]  fill1;
   logic        full1;

   int errors = 0;
   int checks = 0;

   shift_reg #(.width_p(8), .depth_p(4), .reset_val_p(8'hA5)) dut (
      .clk_i(clk), .reset_n_i(reset_n), .clear_i(clear), .en_i(en), .mode_i(mode),
      .data_i(data), .load_i(load), .q_o(q), .head_o(head), .tail_o(tail),
      .fill_o(fill), .full_o(full)
   );

   shift_reg #(.width_p(3), .depth_p(1), .reset_val_p(3'b000)) dut1 (
      .clk_i(clk), .reset_n_i(reset_n), .clear_i(clear1), .en_i(en1), .mode_i(mode1),
      .data_i(data1), .load_i(load1), .q_o(q1), .head_o(head1), .tail_o(tail1),
      .fill_o(fill1), .full_o(full1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // advance to 1 ns after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic e, input logic [1:0] m, input logic [7:0] d);
      en   = e;
      mode = m;
      data = d;
   endtask

   task automatic test_reset();
      drive(1'b1, LOAD, 8'h00);
      load = 32'h01020304;
      tick();
      drive(1'b0, HOLD, 8'h00);
      checks++;
      if (q !== 32'h01020304) begin errors++; $display("FAIL load_before_reset got=%h exp=%h", q, 32'h01020304); end
      #3;
      reset_n = 1'b0;
      #1;
      checks++;
      if (q !== 32'hA5A5A5A5) begin errors++; $display("FAIL async_reset_q got=%h exp=%h", q, 32'hA5A5A5A5); end
      checks++;
      if (fill !== 3'd0 || full !== 1'b0) begin errors++; $display("FAIL async_reset_fill got=%0d/%b exp=0/0", fill, full); end
      checks++;
      if (head !== 8'hA5 || tail !== 8'hA5) begin errors++; $display("FAIL async_reset_ends got=%h/%h exp=a5/a5", head, tail); end
      drive(1'b1, SHIFT_FWD, 8'h99);
      tick();
      checks++;
      if (q !== 32'hA5A5A5A5 || fill !== 3'd0) begin errors++; $display("FAIL reset_hold got=%h/%0d exp=a5a5a5a5/0", q, fill); end
      drive(1'b0, HOLD, 8'h00);
      reset_n = 1'b1;
      tick();
      checks++;
      if (q !== 32'hA5A5A5A5 || fill !== 3'd0) begin errors++; $display("FAIL after_release got=%h/%0d exp=a5a5a5a5/0", q, fill); end
   endtask

   task automatic test_fwd();
      drive(1'b1, SHIFT_FWD, 8'h11);
      tick();
      checks++;
      if (q !== 32'hA5A5A511 || fill !== 3'd1 || full !== 1'b0) begin
         errors++; $display("FAIL fwd_first got=%h/%0d/%b exp=a5a5a511/1/0", q, fill, full);
      end
      drive(1'b1, SHIFT_FWD, 8'h22); tick();
      drive(1'b1, SHIFT_FWD, 8'h33); tick();
      drive(1'b1, SHIFT_FWD, 8'h44); tick();
      checks++;
      if (q !== 32'h11223344) begin errors++; $display("FAIL fwd_q got=%h exp=%h", q, 32'h11223344); end
      checks++;
      if (tail !== 8'h11 || head !== 8'h44) begin errors++; $display("FAIL fwd_ends got=%h/%h exp=11/44", tail, head); end
      checks++;
      if (fill !== 3'd4 || full !== 1'b1) begin errors++; $display("FAIL fwd_full got=%0d/%b exp=4/1", fill, full); end
      drive(1'b1, SHIFT_FWD, 8'h55); tick();
      checks++;
      if (q !== 32'h22334455 || tail !== 8'h22) begin errors++; $display("FAIL fwd_overflow got=%h/%h exp=22334455/22", q, tail); end
      checks++;
      if (fill !== 3'd4 || full !== 1'b1) begin errors++; $display("FAIL fwd_saturate got=%0d/%b exp=4/1", fill, full); end
      drive(1'b0, HOLD, 8'h00);
   endtask

   task automatic test_bwd();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      drive(1'b1, SHIFT_BWD, 8'h12); tick();
      checks++;
      if (q !== 32'h12A5A5A5 || fill !== 3'd1 || tail !== 8'h12) begin
         errors++; $display("FAIL bwd_first got=%h/%0d exp=12a5a5a5/1", q, fill);
      end
      drive(1'b1, LOAD, 8'h00);
      load = 32'h44332211;
      tick();
      checks++;
      if (q !== 32'h44332211 || fill !== 3'd4) begin errors++; $display("FAIL load got=%h/%0d exp=44332211/4", q, fill); end
      drive(1'b1, SHIFT_BWD, 8'hEE); tick();
      checks++;
      if (q !== 32'hEE443322 || head !== 8'h22 || tail !== 8'hEE) begin
         errors++; $display("FAIL bwd_q got=%h head=%h exp=ee443322 head=22", q, head);
      end
      checks++;
      if (fill !== 3'd4 || full !== 1'b1) begin errors++; $display("FAIL bwd_fill got=%0d/%b exp=4/1", fill, full); end
      drive(1'b0, HOLD, 8'h00);
   endtask

   task automatic test_priority();
      drive(1'b1, LOAD, 8'h00);
      load  = 32'hDEADBEEF;
      clear = 1'b1;
      tick();
      clear = 1'b0;
      checks++;
      if (q !== 32'hA5A5A5A5 || fill !== 3'd0 || full !== 1'b0) begin
         errors++; $display("FAIL clear_over_load got=%h/%0d/%b exp=a5a5a5a5/0/0", q, fill, full);
      end
      drive(1'b0, SHIFT_FWD, 8'h77); tick();
      checks++;
      if (q !== 32'hA5A5A5A5 || fill !== 3'd0) begin errors++; $display("FAIL en_low_hold got=%h/%0d exp=a5a5a5a5/0", q, fill); end
      drive(1'b1, HOLD, 8'h77); tick();
      checks++;
      if (q !== 32'hA5A5A5A5 || fill !== 3'd0) begin errors++; $display("FAIL mode_hold got=%h/%0d exp=a5a5a5a5/0", q, fill); end
      drive(1'b1, SHIFT_FWD, 8'h77); tick();
      checks++;
      if (q !== 32'hA5A5A577 || fill !== 3'd1) begin errors++; $display("FAIL fwd_after_clear got=%h/%0d exp=a5a5a577/1", q, fill); end
      drive(1'b0, LOAD, 8'h00);
      load  = 32'h12345678;
      clear = 1'b1;
      tick();
      clear = 1'b0;
      checks++;
      if (q !== 32'hA5A5A5A5 || fill !== 3'd0) begin errors++; $display("FAIL clear_en_low got=%h/%0d exp=a5a5a5a5/0", q, fill); end
      drive(1'b0, HOLD, 8'h00);
   endtask

   task automatic test_depth1();
      checks++;
      if (head1 !== 3'b000 || fill1 !== 1'b0 || full1 !== 1'b0) begin
         errors++; $display("FAIL d1_initial got=%b/%b/%b exp=000/0/0", head1, fill1, full1);
      end
      en1 = 1'b1; mode1 = SHIFT_FWD; data1 = 3'b101;
      tick();
      checks++;
      if (head1 !== 3'b101 || tail1 !== 3'b101 || q1 !== 3'b101) begin
         errors++; $display("FAIL d1_fwd got=%b/%b exp=101/101", head1, tail1);
      end
      checks++;
      if (fill1 !== 1'b1 || full1 !== 1'b1) begin errors++; $display("FAIL d1_full got=%b/%b exp=1/1", fill1, full1); end
      mode1 = SHIFT_BWD; data1 = 3'b010;
      tick();
      checks++;
      if (head1 !== 3'b010 || tail1 !== 3'b010) begin errors++; $display("FAIL d1_bwd got=%b/%b exp=010/010", head1, tail1); end
      mode1 = SHIFT_FWD; data1 = 3'b101;
      tick();
      checks++;
      if (head1 !== 3'b101 || fill1 !== 1'b1 || full1 !== 1'b1) begin
         errors++; $display("FAIL d1_fwd2 got=%b/%b/%b exp=101/1/1", head1, fill1, full1);
      end
      en1 = 1'b0;
      data1 = 3'b111;
      tick();
      checks++;
      if (head1 !== 3'b101) begin errors++; $display("FAIL d1_hold got=%b exp=101", head1); end
   endtask

   task automatic test_async_mid();
      drive(1'b1, SHIFT_FWD, 8'h01); tick();
      drive(1'b1, SHIFT_FWD, 8'h02); tick();
      checks++;
      if (q !== 32'hA5A50102 || fill !== 3'd2) begin errors++; $display("FAIL pre_reset got=%h/%0d exp=a5a50102/2", q, fill); end
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if (q !== 32'hA5A5A5A5 || fill !== 3'd0 || full !== 1'b0) begin
         errors++; $display("FAIL mid_reset got=%h/%0d/%b exp=a5a5a5a5/0/0", q, fill, full);
      end
      checks++;
      if (head1 !== 3'b000 || fill1 !== 1'b0) begin errors++; $display("FAIL mid_reset_d1 got=%b/%b exp=000/0", head1, fill1); end
      tick();
      reset_n = 1'b1;
      drive(1'b1, SHIFT_FWD, 8'h3C); tick();
      checks++;
      if (q !== 32'hA5A5A53C || fill !== 3'd1 || full !== 1'b0) begin
         errors++; $display("FAIL post_reset_fwd got=%h/%0d/%b exp=a5a5a53c/1/0", q, fill, full);
      end
      drive(1'b0, HOLD, 8'h00);
   endtask

   initial begin
      reset_n = 1'b0;
      clear   = 1'b0;
      en      = 1'b0;
      mode    = HOLD;
      data    = 8'h00;
      load    = 32'h0;
      clear1  = 1'b0;
      en1     = 1'b0;
      mode1   = HOLD;
      data1   = 3'b000;
      load1   = 3'b000;
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      test_reset();
      test_fwd();
      test_bwd();
      test_priority();
      test_depth1();
      test_async_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
